// File: rtl/branch_pkg.sv
// Shared opcode/funct3 constants and the result-register state type for the branch unit.
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluation; funct3 010/011 are reserved and flagged illegal.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] src0,
    input  logic [XLEN-1:0] src1,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (src0 == src1);
            F3_BNE:  taken = (src0 != src1);
            F3_BLT:  taken = ($signed(src0) <  $signed(src1));
            F3_BGE:  taken = ($signed(src0) >= $signed(src1));
            F3_BLTU: taken = (src0 <  src1);
            F3_BGEU: taken = (src0 >= src1);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution unit with a single-entry result register (latency 1, full throughput).
// Optional performance counters are built when BRANCH_UNIT_PERF_CNT_EN is defined.
module branch_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  src0,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_cmp_taken;
    logic              w_cmp_illegal;
    logic              w_taken;
    logic              w_illegal;
    logic              w_is_cf;
    logic              w_mispred;
    logic [XLEN-1:0]   w_pc4;
    logic [XLEN-1:0]   w_pc_imm;
    logic [XLEN-1:0]   w_jalr_sum;
    logic [XLEN-1:0]   w_target;

    logic              r_taken;
    logic [XLEN-1:0]   r_target;
    logic [XLEN-1:0]   r_link;
    logic              r_mispred;
    logic              r_illegal;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .src0    (src0),
        .src1    (src1),
        .funct3  (funct3),
        .taken   (w_cmp_taken),
        .illegal (w_cmp_illegal)
    );

    assign in_ready  = (r_state == ST_EMPTY) || out_ready;
    assign w_accept  = in_valid && in_ready && !flush;
    assign out_valid = (r_state == ST_FULL);

    assign w_pc4      = pc + XLEN'(4);
    assign w_pc_imm   = pc + imm;
    assign w_jalr_sum = src0 + imm;

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_is_cf   = 1'b0;
        w_target  = w_pc4;
        case (opcode)
            OP_BRANCH: begin
                w_is_cf   = 1'b1;
                w_taken   = w_cmp_taken;
                w_illegal = w_cmp_illegal;
                w_target  = w_cmp_taken ? w_pc_imm : w_pc4;
            end
            OP_JAL: begin
                w_is_cf  = 1'b1;
                w_taken  = 1'b1;
                w_target = w_pc_imm;
            end
            OP_JALR: begin
                w_is_cf  = 1'b1;
                w_taken  = 1'b1;
                w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
        w_mispred = w_is_cf && (w_taken ^ pred_taken);
    end

    // Flush beats accept and drain; accept while draining keeps the entry FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (flush)          w_state_nxt = ST_EMPTY;
                else if (w_accept)  w_state_nxt = ST_FULL;
                else if (out_ready) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_taken   <= 1'b0;
            r_target  <= '0;
            r_link    <= '0;
            r_mispred <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_taken   <= w_taken;
            r_target  <= w_target;
            r_link    <= w_pc4;
            r_mispred <= w_mispred;
            r_illegal <= w_illegal;
        end
    end

    assign out_taken      = r_taken;
    assign out_target     = r_target;
    assign out_link       = r_link;
    assign out_mispredict = r_mispred;
    assign out_illegal    = r_illegal;

`ifdef BRANCH_UNIT_PERF_CNT_EN
    logic             r_is_cf;
    logic             w_hs_cf;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    // A handshake coinciding with flush is discarded and not counted.
    assign w_hs_cf = out_valid && out_ready && !flush && r_is_cf;

    always_ff @(posedge clk) begin
        if (rst)           r_is_cf <= 1'b0;
        else if (w_accept) r_is_cf <= w_is_cf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else if (w_hs_cf) begin
            if (r_br_cnt != {CNT_W{1'b1}})
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (r_mispred && (r_mis_cnt != {CNT_W{1'b1}}))
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        end
    end

    assign br_count      = r_br_cnt;
    assign mispred_count = r_mis_cnt;
`else
    assign br_count      = '0;
    assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed + short random bench for branch_unit with a queue scoreboard of expected results.
module tb_branch_unit;
    import branch_pkg::*;

    localparam int XLEN = 32;
`ifdef BRANCH_UNIT_PERF_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 32;
`endif

    typedef struct {
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] link;
        logic            mis;
        logic            ill;
        logic            cf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  src0, src1, pc, imm;
    logic             pred_taken, flush;
    logic             out_valid, out_ready;
    logic             out_taken, out_mispredict, out_illegal;
    logic [XLEN-1:0]  out_target, out_link;
    logic [CNT_W-1:0] br_count, mispred_count;

    int     n_vec  = 0;
    int     n_fail = 0;
    exp_t   q[$];
    logic   m_full = 1'b0;
    longint m_br   = 0;
    longint m_mis  = 0;
    longint m_max  = (64'd1 << CNT_W) - 1;

    always #5 clk = ~clk;

    branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3),
        .src0(src0), .src1(src1), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                                   input logic pr);
        exp_t e;
        logic [XLEN-1:0] s;
        e.taken = 1'b0; e.ill = 1'b0; e.cf = 1'b0;
        e.link = p + 32'd4;
        e.target = p + 32'd4;
        if (op == OP_BRANCH) begin
            e.cf = 1'b1;
            if      (f3 == 3'b000) e.taken = (a == b);
            else if (f3 == 3'b001) e.taken = (a != b);
            else if (f3 == 3'b100) e.taken = ($signed(a) < $signed(b));
            else if (f3 == 3'b101) e.taken = !($signed(a) < $signed(b));
            else if (f3 == 3'b110) e.taken = (a < b);
            else if (f3 == 3'b111) e.taken = !(a < b);
            else                   e.ill = 1'b1;
            if (e.taken) e.target = p + im;
        end else if (op == OP_JAL) begin
            e.cf = 1'b1; e.taken = 1'b1; e.target = p + im;
        end else if (op == OP_JALR) begin
            e.cf = 1'b1; e.taken = 1'b1;
            s = a + im;
            e.target = s & ~32'd1;
        end
        e.mis = e.cf ? (e.taken != pr) : 1'b0;
        return e;
    endfunction

    task automatic drv(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] im, input logic pr);
        in_valid = v; opcode = op; funct3 = f3; src0 = a; src1 = b;
        pc = p; imm = im; pred_taken = pr;
    endtask

    // One clock: update the model from the applied inputs, clock, then check outputs.
    task automatic cyc();
        logic hs, acc;
        exp_t e;
        #1;
        if (rst) begin
            m_full = 1'b0; q.delete(); m_br = 0; m_mis = 0;
        end else begin
            chk("in_ready", in_ready, !m_full || out_ready);
            hs  = m_full && out_ready && !flush;
            acc = in_valid && (!m_full || out_ready) && !flush;
            if (flush && m_full) begin
                void'(q.pop_front());
            end else if (hs) begin
                e = q.pop_front();
`ifdef BRANCH_UNIT_PERF_CNT_EN
                if (e.cf && m_br < m_max) m_br++;
                if (e.cf && e.mis && m_mis < m_max) m_mis++;
`endif
            end
            if (acc) q.push_back(model(opcode, funct3, src0, src1, pc, imm, pred_taken));
            m_full = flush ? 1'b0 : acc ? 1'b1 : hs ? 1'b0 : m_full;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_full);
        if (m_full && q.size() > 0) begin
            chk("out_taken",  out_taken,      q[0].taken);
            chk("out_target", out_target,     q[0].target);
            chk("out_link",   out_link,       q[0].link);
            chk("out_mispr",  out_mispredict, q[0].mis);
            chk("out_illegal", out_illegal,   q[0].ill);
        end
        chk("br_count",      br_count,      m_br);
        chk("mispred_count", mispred_count, m_mis);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drv(1'b0, 7'd0, 3'd0, '0, '0, '0, '0, 1'b0);
        cyc(); cyc();
        chk("rst_taken",  out_taken, 1'b0);
        chk("rst_target", out_target, 32'd0);
        chk("rst_link",   out_link, 32'd0);
        chk("rst_mispr",  out_mispredict, 1'b0);
        chk("rst_ill",    out_illegal, 1'b0);
        rst = 1'b0;

        drv(1'b1, OP_BRANCH, F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
        cyc();
        chk("blt_taken",  out_taken, 1'b1);
        chk("blt_target", out_target, 32'h120);
        drv(1'b1, OP_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
        cyc();
        chk("bltu_taken",  out_taken, 1'b0);
        chk("bltu_target", out_target, 32'h104);
        drv(1'b1, OP_JALR, 3'd0, 32'h1001, 32'd0, 32'h200, 32'd4, 1'b0);
        cyc();
        chk("jalr_target", out_target, 32'h1004);
        chk("jalr_link",   out_link, 32'h204);
        chk("jalr_mispr",  out_mispredict, 1'b1);

        // Back-pressure: held JALR must stay put while the BEQ waits.
        out_ready = 1'b0;
        drv(1'b1, OP_BRANCH, F3_BEQ, 32'h5, 32'h5, 32'h300, 32'h40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_target",   out_target, 32'h1004);
        end
        out_ready = 1'b1;
        cyc();
        chk("b2b_valid",  out_valid, 1'b1);
        chk("b2b_target", out_target, 32'h340);

        flush = 1'b1;
        drv(1'b1, OP_JAL, 3'd0, '0, '0, 32'h400, 32'h10, 1'b0);
        cyc();
        chk("flush_valid", out_valid, 1'b0);
        flush = 1'b0;

        drv(1'b1, OP_BRANCH, 3'b010, 32'h1, 32'h1, 32'h500, 32'h8, 1'b1);
        cyc();
        chk("ill_flag",  out_illegal, 1'b1);
        chk("ill_taken", out_taken, 1'b0);
        drv(1'b1, OP_BRANCH, F3_BNE, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b0);
        cyc();
        chk("wrap_target", out_target, 32'h0);
        drv(1'b1, OP_JAL, 3'd0, '0, '0, 32'h600, 32'hFFFF_FFF0, 1'b1);
        cyc();
        chk("jal_target", out_target, 32'h5F0);
        drv(1'b1, 7'b0110011, 3'd0, 32'h1, 32'h1, 32'h700, 32'h8, 1'b1);
        cyc();
        chk("other_mispr", out_mispredict, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [6:0] ops [4];
            logic [XLEN-1:0] a;
            ops = '{OP_BRANCH, OP_JAL, OP_JALR, 7'b0010011};
            a = $urandom();
            drv(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                a, ($urandom_range(0, 2) == 0) ? a : 32'($urandom()),
                32'($urandom()), 32'($urandom()), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 3) != 0);
            cyc();
        end

        // Reset while FULL with competing flush/accept.
        out_ready = 1'b0;
        drv(1'b1, OP_JAL, 3'd0, '0, '0, 32'h800, 32'h4, 1'b0);
        cyc();
        rst = 1'b1; flush = 1'b1;
        cyc();
        chk("midrst_valid",  out_valid, 1'b0);
        chk("midrst_target", out_target, 32'h0);
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drv(1'b1, OP_BRANCH, F3_BEQ, 32'h1, 32'h2, 32'h900, 32'h10, 1'b1);
            cyc();
        end
        drv(1'b0, 7'd0, 3'd0, '0, '0, '0, '0, 1'b0);
        cyc();
`ifdef BRANCH_UNIT_PERF_CNT_EN
        chk("sat_br",  br_count, 3);
        chk("sat_mis", mispred_count, 3);
`else
        chk("nocnt_br",  br_count, 0);
        chk("nocnt_mis", mispred_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/PC width.
REQ-002 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: request handshake.
REQ-006 SHALL have ports opcode input 7, funct3 input 3, src0 input XLEN, src1 input XLEN, pc input XLEN, imm input XLEN, pred_taken input 1: request payload.
REQ-007 SHALL have port flush  input  1  discard held result and current request.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-009 SHALL have ports out_taken output 1, out_target output XLEN, out_link output XLEN, out_mispredict output 1, out_illegal output 1: result payload.
REQ-010 SHALL have ports br_count output CNT_W and mispred_count output CNT_W: performance counters.

Function
REQ-011 SHALL hold one result register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-013 SHALL accept a request when in_valid && in_ready && !flush; result visible the next cycle (latency 1).
REQ-014 SHALL transition EMPTY->FULL on accept, FULL->EMPTY on out_ready without accept, and FULL->FULL on simultaneous drain and accept (back-to-back, full throughput).
REQ-015 SHALL keep all out_* stable while out_valid && !out_ready.
REQ-016 SHALL, on flush, go to EMPTY next cycle regardless of in_valid/out_ready; flush has priority over accept and drain.
REQ-017 SHALL decode opcode 1100011 with funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
REQ-018 SHALL, for branch funct3 010/011, set out_taken=0, out_illegal=1, out_target=pc+4.
REQ-019 SHALL, for branches, set out_target=pc+imm if taken, else pc+4.
REQ-020 SHALL, for JAL (1101111), set out_taken=1, out_target=pc+imm.
REQ-021 SHALL, for JALR (1100111), set out_taken=1, out_target=(src0+imm) with bit 0 cleared.
REQ-022 SHALL set out_link=pc+4 for every opcode.
REQ-023 SHALL, for any other opcode, set out_taken=0, out_target=pc+4, out_illegal=0.
REQ-024 SHALL compute out_mispredict = out_taken XOR pred_taken for branch/JAL/JALR, and 0 otherwise.
REQ-025 SHALL compute all additions modulo 2^XLEN; wrap-around is silent.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set state EMPTY and out_taken, out_target, out_link, out_mispredict, out_illegal, br_count and mispred_count to 0.
REQ-027 SHALL take reset over flush and accept, and drop any held result on reset mid-operation.

Configuration
REQ-028 SHALL compile the counters only when BRANCH_UNIT_PERF_CNT_EN is defined.
REQ-029 SHALL, with the macro defined, increment br_count on each result handshake (out_valid && out_ready) of a branch/JAL/JALR, and increment mispred_count on such a handshake with out_mispredict=1.
REQ-030 SHALL saturate both counters at 2^CNT_W-1.
REQ-031 SHALL, without the macro, keep both counter ports present and tied to 0, with no counter flops.

Structure
REQ-032 SHALL place the opcode constants (BRANCH, JAL, JALR) and the funct3 constants in shared package branch_pkg.
REQ-033 SHALL implement the compare in combinational sub-module branch_cmp (src0, src1, funct3 -> taken, illegal); all sequential logic stays in branch_unit.

Verification
REQ-034 SHALL check BLT, src0=32'hFFFF_FFFF, src1=1, pc=0x100, imm=0x20 -> out_taken=1, out_target=0x120; and BLTU with the same operands -> out_taken=0, out_target=0x104.
REQ-035 SHALL check JALR, src0=0x1001, imm=4, pc=0x200, pred_taken=0 -> out_target=0x1004, out_link=0x204, out_mispredict=1.
REQ-036 SHALL check out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable; then out_ready=1 -> drain and accept in the same cycle, out_valid remains 1.
REQ-037 SHALL check flush=1 with in_valid=1 and a FULL result -> out_valid=0 next cycle, and no counter increment.
REQ-038 SHALL check funct3=010 on a branch -> out_illegal=1, out_taken=0; and pc=32'hFFFF_FFFC on a not-taken branch -> out_target=0.
REQ-039 SHALL, with the macro defined and CNT_W=2, run 5 mispredicted branch handshakes -> br_count=3, mispred_count=3 (saturated).
